// File: rtl/traffic_pkg.sv
// Shared types and helpers for the intersection phase controller: phase encoding,
// active-low lamp patterns, phase sequencing and per-phase durations.
package traffic_pkg;

  typedef enum logic [2:0] {
    AR_A  = 3'd0,
    NS_G  = 3'd1,
    NS_Y  = 3'd2,
    AR_B  = 3'd3,
    EW_G  = 3'd4,
    EW_Y  = 3'd5,
    NIGHT = 3'd6
  } phase_t;

  // Lamp bit order is {green, yellow, red}; 0 = lit.
  localparam logic [2:0] LAMP_RED = 3'b110;
  localparam logic [2:0] LAMP_YEL = 3'b101;
  localparam logic [2:0] LAMP_GRN = 3'b011;
  localparam logic [2:0] LAMP_OFF = 3'b111;

  typedef struct packed {
    logic [2:0] ns;
    logic [2:0] ew;
  } lamp_pair_t;

  function automatic phase_t next_phase(input phase_t p);
    case (p)
      AR_A:    return NS_G;
      NS_G:    return NS_Y;
      NS_Y:    return AR_B;
      AR_B:    return EW_G;
      EW_G:    return EW_Y;
      EW_Y:    return AR_A;
      default: return AR_A;
    endcase
  endfunction

  function automatic logic [6:0] phase_duration(input phase_t     p,
                                                input logic [6:0] t_green,
                                                input logic [6:0] t_yellow,
                                                input logic [6:0] t_allred);
    case (p)
      NS_G, EW_G: return t_green;
      NS_Y, EW_Y: return t_yellow;
      AR_A, AR_B: return t_allred;
      default:    return '0;
    endcase
  endfunction

  function automatic logic is_allred(input phase_t p);
    return (p == AR_A) || (p == AR_B);
  endfunction

  // Pedestrian pending bit served by the given phase: [0] NS green, [1] EW green.
  function automatic logic [1:0] green_mask(input phase_t p);
    case (p)
      NS_G:    return 2'b01;
      EW_G:    return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic lamp_pair_t phase_lamps(input phase_t p, input logic flash);
    lamp_pair_t l;
    l.ns = LAMP_RED;
    l.ew = LAMP_RED;
    case (p)
      NS_G:  l.ns = LAMP_GRN;
      NS_Y:  l.ns = LAMP_YEL;
      EW_G:  l.ew = LAMP_GRN;
      EW_Y:  l.ew = LAMP_YEL;
      NIGHT: begin
        l.ns = flash ? LAMP_YEL : LAMP_OFF;
        l.ew = l.ns;
      end
      default: ;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/bin2bcd99.sv
// Combinational binary (0..99) to two-digit BCD converter for the countdown display.
module bin2bcd99 (
  input  logic [6:0] bin_i,
  output logic [3:0] tens_o,
  output logic [3:0] ones_o
);

  logic [6:0] rest;

  // Repeated subtraction; nine steps cover the full 0..99 range.
  always_comb begin
    tens_o = '0;
    rest   = bin_i;
    for (int unsigned i = 0; i < 9; i++) begin
      if (rest >= 7'd10) begin
        rest   = rest - 7'd10;
        tens_o = tens_o + 4'd1;
      end
    end
    ones_o = rest[3:0];
  end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Two-direction intersection sequencer: phase FSM with per-phase countdown, pedestrian
// green-shortening requests, night flashing mode, registered lamps and BCD countdown.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned T_GREEN  = 30,
  parameter int unsigned T_YELLOW = 5,
  parameter int unsigned T_ALLRED = 2,
  parameter int unsigned PED_CUT  = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic [1:0] ped_req,
  input  logic       night_mode,
  output logic [2:0] ns_lamp,
  output logic [2:0] ew_lamp,
  output logic [2:0] phase,
  output logic [3:0] remain_tens,
  output logic [3:0] remain_ones,
  output logic       phase_start
);

  localparam logic [6:0] TG7  = 7'(T_GREEN);
  localparam logic [6:0] TY7  = 7'(T_YELLOW);
  localparam logic [6:0] TAR7 = 7'(T_ALLRED);
  localparam logic [6:0] CUT7 = 7'(PED_CUT);
  localparam logic [3:0] AR_TENS = 4'(T_ALLRED / 10);
  localparam logic [3:0] AR_ONES = 4'(T_ALLRED % 10);

  phase_t     phase_q,  phase_d;
  logic [6:0] remain_q, remain_d;
  logic [1:0] pend_q,   pend_d;
  logic       flash_q,  flash_d;
  logic       start_q,  start_d;
  lamp_pair_t lamps_q,  lamps_d;
  logic [3:0] tens_q,   tens_d;
  logic [3:0] ones_q,   ones_d;
  logic       cut_req;

  bin2bcd99 u_bcd (
    .bin_i  (remain_q),
    .tens_o (tens_d),
    .ones_o (ones_d)
  );

  always_comb begin
    phase_d  = phase_q;
    remain_d = remain_q;
    flash_d  = flash_q;
    start_d  = 1'b0;
    cut_req  = ((phase_q == NS_G) && pend_q[1]) || ((phase_q == EW_G) && pend_q[0]);

    case (phase_q)
      AR_A, NS_G, NS_Y, AR_B, EW_G, EW_Y: begin
        if (tick_1hz) begin
          if (remain_q <= 7'd1) begin
            start_d = 1'b1;
            // night_mode only matters when an all-red clearance expires.
            if (is_allred(phase_q) && night_mode) begin
              phase_d  = NIGHT;
              remain_d = '0;
              flash_d  = 1'b1;
            end else begin
              phase_d  = next_phase(phase_q);
              remain_d = phase_duration(next_phase(phase_q), TG7, TY7, TAR7);
            end
          end else if (cut_req && (remain_q > CUT7)) begin
            remain_d = CUT7;
          end else begin
            remain_d = remain_q - 7'd1;
          end
        end
      end
      NIGHT: begin
        if (tick_1hz) begin
          if (!night_mode) begin
            phase_d  = AR_A;
            remain_d = TAR7;
            start_d  = 1'b1;
          end else begin
            flash_d = ~flash_q;
          end
        end
      end
      default: begin
        phase_d  = AR_A;
        remain_d = TAR7;
        start_d  = 1'b1;
      end
    endcase

    // Requests latch every cycle; a request for the green being entered or shown is dropped.
    pend_d  = (pend_q | ped_req) & ~green_mask(phase_d);
    lamps_d = phase_lamps(phase_q, flash_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q  <= AR_A;
      remain_q <= TAR7;
      pend_q   <= '0;
      flash_q  <= 1'b0;
      start_q  <= 1'b0;
      lamps_q  <= '{ns: LAMP_RED, ew: LAMP_RED};
      tens_q   <= AR_TENS;
      ones_q   <= AR_ONES;
    end else begin
      phase_q  <= phase_d;
      remain_q <= remain_d;
      pend_q   <= pend_d;
      flash_q  <= flash_d;
      start_q  <= start_d;
      lamps_q  <= lamps_d;
      tens_q   <= tens_d;
      ones_q   <= ones_d;
    end
  end

  assign ns_lamp     = lamps_q.ns;
  assign ew_lamp     = lamps_q.ew;
  assign phase       = phase_q;
  assign remain_tens = tens_q;
  assign remain_ones = ones_q;
  assign phase_start = start_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Self-checking bench for traffic_phase_ctrl: table-driven phase-ring model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_traffic_phase_ctrl;
  import traffic_pkg::*;

  localparam int TG   = 8;
  localparam int TY   = 3;
  localparam int TAR  = 2;
  localparam int TCUT = 3;

  logic       clk        = 1'b0;
  logic       rst_n      = 1'b0;
  logic       tick_1hz   = 1'b0;
  logic [1:0] ped_req    = 2'b00;
  logic       night_mode = 1'b0;
  logic [2:0] ns_lamp, ew_lamp, phase;
  logic [3:0] remain_tens, remain_ones;
  logic       phase_start;

  int checks    = 0;
  int errors    = 0;
  int start_cnt = 0;

  traffic_phase_ctrl #(
    .T_GREEN  (TG),
    .T_YELLOW (TY),
    .T_ALLRED (TAR),
    .PED_CUT  (TCUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick_1hz    (tick_1hz),
    .ped_req     (ped_req),
    .night_mode  (night_mode),
    .ns_lamp     (ns_lamp),
    .ew_lamp     (ew_lamp),
    .phase       (phase),
    .remain_tens (remain_tens),
    .remain_ones (remain_ones),
    .phase_start (phase_start)
  );

  always #5 clk = ~clk;

  // Model: position on the six-phase ring, seconds left, night flag, pending requests.
  phase_t     ring   [6] = '{AR_A, NS_G, NS_Y, AR_B, EW_G, EW_Y};
  int         dur    [6] = '{TAR, TG, TY, TAR, TG, TY};
  logic [2:0] ns_tab [6] = '{3'b110, 3'b011, 3'b101, 3'b110, 3'b110, 3'b110};
  logic [2:0] ew_tab [6] = '{3'b110, 3'b110, 3'b110, 3'b110, 3'b011, 3'b101};

  int         m_pos   = 0;
  int         m_rem   = TAR;
  bit         m_night = 1'b0;
  bit         m_flash = 1'b0;
  logic [1:0] m_pend  = 2'b00;
  logic [2:0] e_ns    = 3'b110;
  logic [2:0] e_ew    = 3'b110;
  int         e_shown = TAR;
  bit         e_start = 1'b0;

  function automatic phase_t m_phase();
    return m_night ? NIGHT : ring[m_pos];
  endfunction

  initial forever begin
    bit cut;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_pos = 0; m_rem = TAR; m_night = 1'b0; m_flash = 1'b0; m_pend = 2'b00;
      e_ns = 3'b110; e_ew = 3'b110; e_shown = TAR; e_start = 1'b0;
    end else begin
      e_ns    = m_night ? (m_flash ? 3'b101 : 3'b111) : ns_tab[m_pos];
      e_ew    = m_night ? (m_flash ? 3'b101 : 3'b111) : ew_tab[m_pos];
      e_shown = m_rem;
      e_start = 1'b0;
      cut = !m_night && (m_rem > TCUT) &&
            ((m_pos == 1 && m_pend[1]) || (m_pos == 4 && m_pend[0]));
      if (tick_1hz) begin
        if (m_night) begin
          if (!night_mode) begin
            m_night = 1'b0; m_pos = 0; m_rem = TAR; e_start = 1'b1;
          end else begin
            m_flash = !m_flash;
          end
        end else if (m_rem == 1) begin
          e_start = 1'b1;
          if ((m_pos == 0 || m_pos == 3) && night_mode) begin
            m_night = 1'b1; m_rem = 0; m_flash = 1'b1;
          end else begin
            m_pos = (m_pos + 1) % 6;
            m_rem = dur[m_pos];
          end
        end else if (cut) begin
          m_rem = TCUT;
        end else begin
          m_rem = m_rem - 1;
        end
      end
      m_pend = m_pend | ped_req;
      if (!m_night && m_pos == 1) m_pend[0] = 1'b0;
      if (!m_night && m_pos == 4) m_pend[1] = 1'b0;
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic bcd_is(input string nm, input int t, input int o);
    chk({nm, "_tens"}, int'(remain_tens), t);
    chk({nm, "_ones"}, int'(remain_ones), o);
  endtask

  initial forever begin
    @(negedge clk);
    chk("phase", int'(phase), int'(m_phase()));
    chk("ns_lamp", int'(ns_lamp), int'(e_ns));
    chk("ew_lamp", int'(ew_lamp), int'(e_ew));
    chk("bcd_tens", int'(remain_tens), e_shown / 10);
    chk("bcd_ones", int'(remain_ones), e_shown % 10);
    chk("phase_start", int'(phase_start), int'(e_start));
    if (phase_start) start_cnt++;
  end

  task automatic tick_once(input logic [1:0] req = 2'b00);
    @(negedge clk);
    tick_1hz = 1'b1;
    ped_req  = req;
    @(negedge clk);
    tick_1hz = 1'b0;
    ped_req  = 2'b00;
    repeat (8) @(negedge clk);
  endtask

  task automatic pulse_ped(input logic [1:0] req);
    @(negedge clk);
    ped_req = req;
    @(negedge clk);
    ped_req = 2'b00;
  endtask

  task automatic advance_to(input phase_t p, input int rem);
    int n = 0;
    while (!(m_phase() == p && m_rem == rem) && n < 60) begin
      tick_once();
      n++;
    end
    checks++;
    if (n >= 60) begin
      errors++;
      $display("FAIL advance_timeout: got %0d ticks expected < 60 (target phase %0d)", n, int'(p));
    end
    chk("advance_phase", int'(phase), int'(p));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_phase", int'(phase), 0);
    chk("rst_ns", int'(ns_lamp), 3'b110);
    chk("rst_ew", int'(ew_lamp), 3'b110);
    chk("rst_start", int'(phase_start), 0);
    bcd_is("rst_bcd", 0, 2);
    rst_n = 1'b1;

    // Free-running sequence, no requests
    start_cnt = 0;
    for (int i = 1; i <= 40; i++) begin
      tick_once();
      if (i == 5) begin
        chk("nsg_ns", int'(ns_lamp), 3'b011);
        chk("nsg_ew", int'(ew_lamp), 3'b110);
        bcd_is("nsg_bcd", 0, 5);
      end
    end
    chk("seq_starts", start_cnt, 9);
    chk("seq_phase", int'(phase), 3);
    bcd_is("seq_bcd", 0, 1);

    // Pedestrian cut at remain 7
    advance_to(NS_G, 7);
    pulse_ped(2'b10);
    tick_once();
    chk("cut_phase", int'(phase), 1);
    bcd_is("cut_bcd", 0, 3);
    tick_once();
    tick_once();
    tick_once();
    chk("cut_ny", int'(phase), 2);
    bcd_is("cut_ny_bcd", 0, 3);
    advance_to(EW_G, 8);
    advance_to(NS_G, 8);
    tick_once();
    bcd_is("pend_clr_bcd", 0, 7);

    // Late request: no cut; own-direction request ignored
    advance_to(NS_G, 2);
    pulse_ped(2'b10);
    tick_once();
    bcd_is("late_bcd", 0, 1);
    tick_once();
    chk("late_ny", int'(phase), 2);
    bcd_is("late_ny_bcd", 0, 3);
    advance_to(NS_G, 7);
    pulse_ped(2'b01);
    tick_once();
    bcd_is("own_bcd", 0, 6);
    advance_to(EW_G, 8);
    tick_once();
    bcd_is("own_ewg_bcd", 0, 7);

    // Request coincident with tick
    advance_to(NS_G, 6);
    tick_once(2'b10);
    bcd_is("same_bcd", 0, 5);
    tick_once();
    bcd_is("same_cut_bcd", 0, 3);

    // Night mode
    advance_to(EW_G, 5);
    night_mode = 1'b1;
    advance_to(NIGHT, 0);
    chk("night_ns_lit", int'(ns_lamp), 3'b101);
    chk("night_ew_lit", int'(ew_lamp), 3'b101);
    bcd_is("night_bcd", 0, 0);
    tick_once();
    chk("night_ns_off", int'(ns_lamp), 3'b111);
    chk("night_ew_off", int'(ew_lamp), 3'b111);
    tick_once();
    chk("night_ns_lit2", int'(ns_lamp), 3'b101);
    night_mode = 1'b0;
    tick_once();
    chk("night_exit", int'(phase), 0);
    bcd_is("night_exit_bcd", 0, 2);

    // Asynchronous reset mid-NS_Y
    advance_to(NS_Y, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_phase", int'(phase), 0);
    chk("arst_ns", int'(ns_lamp), 3'b110);
    chk("arst_ew", int'(ew_lamp), 3'b110);
    chk("arst_start", int'(phase_start), 0);
    bcd_is("arst_bcd", 0, 2);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick_once();
    chk("post_rst_phase", int'(phase), 0);
    bcd_is("post_rst_bcd", 0, 1);
    advance_to(NS_G, 8);
    chk("post_rst_ns", int'(ns_lamp), 3'b011);
    bcd_is("post_rst_ng_bcd", 0, 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
